// File: rtl/tlb_pkg.sv
// Shared types for the Sv39 TLB: entry layout, field widths and controller states.
package TlbPkg;

  localparam int VPN_W = 27;
  localparam int PPN_W = 44;

  typedef struct packed {
    logic             valid;
    logic [VPN_W-1:0] vpn;
    logic [PPN_W-1:0] ppn;
  } TLBEntry;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WREQ = 2'd1,
    WAIT = 2'd2
  } tlb_state_t;

endpackage

// File: rtl/tlb_match.sv
// Combinational tag compare over all TLB entries plus first-free-slot search.
module tlb_match
  import TlbPkg::*;
#(
  parameter int ENTRIES = 8
) (
  input  logic                       clk_unused,
  input  TLBEntry                    entries [ENTRIES],
  input  logic [VPN_W-1:0]           vpn,
  output logic                       match,
  output logic [ENTRIES-1:0]         hit_onehot,
  output logic [$clog2(ENTRIES)-1:0] inv_idx,
  output logic                       any_invalid
);

  localparam int IDX_W = $clog2(ENTRIES);

  // Walk from the top so the lowest-index invalid entry is the one left in inv_idx.
  always_comb begin
    hit_onehot  = '0;
    inv_idx     = '0;
    any_invalid = 1'b0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (entries[i].valid && (entries[i].vpn == vpn)) begin
        hit_onehot[i] = 1'b1;
      end
      if (!entries[i].valid) begin
        inv_idx     = IDX_W'(i);
        any_invalid = 1'b1;
      end
    end
    match = |hit_onehot;
  end

endmodule

// File: rtl/tlb.sv
// Sv39 fully associative TLB in front of the page-table walker, 4 KiB pages only.
// Optional performance counters are built when TLB_PERF_EN is defined.
module tlb
  import TlbPkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int ENTRIES    = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req,
  input  logic [ADDR_WIDTH-1:0] va,
  output logic                  ready,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] pa,
  output logic                  fault,
  input  logic                  flush,
  output logic                  walk_req,
  output logic [ADDR_WIDTH-1:0] walk_va,
  input  logic                  walk_finish,
  input  logic [ADDR_WIDTH-1:0] walk_pa,
  input  logic                  walk_hit
`ifdef TLB_PERF_EN
  ,
  output logic [63:0]           hit_cnt,
  output logic [63:0]           miss_cnt
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);

  tlb_state_t       state;
  logic             flushed;
  logic [IDX_W-1:0] rr_ptr;
  logic [ENTRIES-1:0] valid;
  logic [VPN_W-1:0] vpn_arr [ENTRIES];
  logic [PPN_W-1:0] ppn_arr [ENTRIES];
  TLBEntry          entries [ENTRIES];

  logic               match;
  logic [ENTRIES-1:0] hit_onehot;
  logic [IDX_W-1:0]   inv_idx;
  logic               any_invalid;
  logic [PPN_W-1:0]   ppn_sel;
  logic [IDX_W-1:0]   victim;
  logic               accept;
  logic               hit;
  logic               miss;
  logic               fill_en;

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      entries[i] = '{valid: valid[i], vpn: vpn_arr[i], ppn: ppn_arr[i]};
    end
  end

  tlb_match #(.ENTRIES(ENTRIES)) u_match (
    .clk_unused  (clk),
    .entries     (entries),
    .vpn         (va[38:12]),
    .match       (match),
    .hit_onehot  (hit_onehot),
    .inv_idx     (inv_idx),
    .any_invalid (any_invalid)
  );

  always_comb begin
    ppn_sel = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      ppn_sel = ppn_sel | (ppn_arr[i] & {PPN_W{hit_onehot[i]}});
    end
  end

  assign ready    = (state == IDLE) & ~flush;
  assign accept   = req & ready;
  assign hit      = accept & match;
  assign miss     = accept & ~match;
  assign walk_req = (state == WREQ);
  // A flush in the finishing cycle also blocks the fill: the valid clear wins that edge.
  assign fill_en  = (state == WAIT) & walk_finish & walk_hit & ~flushed & ~flush;
  assign victim   = any_invalid ? inv_idx : rr_ptr;

  always_comb begin
    done  = 1'b0;
    pa    = '0;
    fault = 1'b0;
    if (hit) begin
      done = 1'b1;
      pa   = ADDR_WIDTH'({ppn_sel, va[11:0]});
    end else if ((state == WAIT) && walk_finish) begin
      done  = 1'b1;
      pa    = walk_pa;
      fault = ~walk_hit;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      flushed <= 1'b0;
      walk_va <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss) begin
            state   <= WREQ;
            walk_va <= va;
          end
        end
        WREQ: begin
          state <= WAIT;
          if (flush) flushed <= 1'b1;
        end
        WAIT: begin
          if (walk_finish) begin
            state   <= IDLE;
            flushed <= 1'b0;
          end else if (flush) begin
            flushed <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid  <= '0;
      rr_ptr <= '0;
    end else begin
      if (flush) begin
        valid <= '0;
      end else if (fill_en) begin
        valid[victim] <= 1'b1;
      end
      if (fill_en) rr_ptr <= rr_ptr + 1'b1;
    end
  end

  // Tag and PPN storage is qualified by valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      vpn_arr[victim] <= walk_va[38:12];
      ppn_arr[victim] <= walk_pa[55:12];
    end
  end

`ifdef TLB_PERF_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit)  hit_cnt  <= hit_cnt + 64'd1;
      if (miss) miss_cnt <= miss_cnt + 64'd1;
    end
  end
`endif

endmodule
